// File: rtl/dmem_access_unit.sv
// dmem_access_unit: MEM-stage load/store initiator on a valid/ready data bus.
// Stalls the pipeline per access and holds the registered, extended load result.
module dmem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        Mem_R_En_M,
    input  logic        Mem_W_En_M,
    input  logic [2:0]  Funct3_M,
    input  logic [31:0] ALU_Out_M,
    input  logic [31:0] Store_Data_M,
    output logic        Stall_M,
    output logic        Misalign_M,
    output logic        Bus_Err_M,
    output logic [31:0] Data_Out_Ext_M,
    output logic        BUS_Valid,
    output logic        BUS_We,
    output logic [31:0] BUS_Addr,
    output logic [31:0] BUS_Wdata,
    output logic [3:0]  BUS_Strb,
    input  logic        BUS_Ready,
    input  logic [31:0] BUS_Rdata
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;
    state_e      state_q;
    logic [7:0]  cnt_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        is_load_q, valid_q, we_q, err_q;
    logic [31:0] addr_q, wdata_q, data_q;
    logic [3:0]  strb_q;
    logic        acc, ld, sz_b, sz_h, sz_w;
    logic [3:0]  strb_d;
    logic [31:0] wdata_d, lane, data_d;

    assign acc  = Mem_R_En_M | Mem_W_En_M;
    assign ld   = Mem_R_En_M;
    // funct3[2] only selects zero-extension on loads; on stores it makes the code undefined (treated as SW)
    assign sz_b = (Funct3_M[1:0] == 2'b00) && (ld || !Funct3_M[2]);
    assign sz_h = (Funct3_M[1:0] == 2'b01) && (ld || !Funct3_M[2]);
    assign sz_w = !sz_b && !sz_h;

    assign Misalign_M = acc && ((sz_h && ALU_Out_M[0]) || (sz_w && ALU_Out_M[1:0] != 2'b00));
    assign Stall_M    = (state_q == IDLE && acc && !Misalign_M) || state_q == REQ;

    assign strb_d  = ld ? 4'b0000 : sz_b ? 4'b0001 << ALU_Out_M[1:0] : sz_h ? 4'b0011 << ALU_Out_M[1:0] : 4'b1111;
    assign wdata_d = sz_b ? {4{Store_Data_M[7:0]}} : sz_h ? {2{Store_Data_M[15:0]}} : Store_Data_M;

    assign lane   = BUS_Rdata >> {off_q, 3'b000};
    assign data_d = f3_q[1:0] == 2'b00 ? {{24{lane[7] & ~f3_q[2]}}, lane[7:0]}
                  : f3_q[1:0] == 2'b01 ? {{16{lane[15] & ~f3_q[2]}}, lane[15:0]} : lane;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            f3_q      <= 3'd0;
            off_q     <= 2'd0;
            is_load_q <= 1'b0;
            valid_q   <= 1'b0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            strb_q    <= 4'd0;
            data_q    <= 32'd0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: if (acc && !Misalign_M) begin
                    state_q   <= REQ;
                    valid_q   <= 1'b1;
                    we_q      <= !ld;
                    addr_q    <= {ALU_Out_M[31:2], 2'b00};
                    wdata_q   <= wdata_d;
                    strb_q    <= strb_d;
                    f3_q      <= Funct3_M;
                    off_q     <= ALU_Out_M[1:0];
                    is_load_q <= ld;
                    cnt_q     <= 8'(TIMEOUT_CYCLES - 1);
                end
                REQ: if (BUS_Ready) begin
                    state_q <= DONE;
                    valid_q <= 1'b0;
                    if (is_load_q) data_q <= data_d;
                end else if (cnt_q == 8'd0) begin
                    state_q <= DONE;
                    valid_q <= 1'b0;
                    data_q  <= 32'd0;
                    err_q   <= 1'b1;
                end else begin
                    cnt_q <= cnt_q - 8'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Bus_Err_M      = err_q;
    assign Data_Out_Ext_M = data_q;
    assign BUS_Valid      = valid_q;
    assign BUS_We         = we_q;
    assign BUS_Addr       = addr_q;
    assign BUS_Wdata      = wdata_q;
    assign BUS_Strb       = strb_q;
endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: table-driven bench with a writeback-data scoreboard and reset corner sequences.
module tb_dmem_access_unit;
    localparam int T = 4;
    logic        CLK = 1'b0, RST_N = 1'b0;
    logic        Mem_R_En_M = 1'b0, Mem_W_En_M = 1'b0;
    logic [2:0]  Funct3_M = 3'd0;
    logic [31:0] ALU_Out_M = 32'd0, Store_Data_M = 32'd0;
    logic        Stall_M, Misalign_M, Bus_Err_M;
    logic [31:0] Data_Out_Ext_M;
    logic        BUS_Valid, BUS_We;
    logic [31:0] BUS_Addr, BUS_Wdata;
    logic [3:0]  BUS_Strb;
    logic        BUS_Ready = 1'b0;
    logic [31:0] BUS_Rdata = 32'd0;

    dmem_access_unit #(.TIMEOUT_CYCLES(T)) dut (
        .CLK(CLK), .RST_N(RST_N), .Mem_R_En_M(Mem_R_En_M), .Mem_W_En_M(Mem_W_En_M),
        .Funct3_M(Funct3_M), .ALU_Out_M(ALU_Out_M), .Store_Data_M(Store_Data_M),
        .Stall_M(Stall_M), .Misalign_M(Misalign_M), .Bus_Err_M(Bus_Err_M),
        .Data_Out_Ext_M(Data_Out_Ext_M), .BUS_Valid(BUS_Valid), .BUS_We(BUS_We),
        .BUS_Addr(BUS_Addr), .BUS_Wdata(BUS_Wdata), .BUS_Strb(BUS_Strb),
        .BUS_Ready(BUS_Ready), .BUS_Rdata(BUS_Rdata)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        ren, wen;
        logic [2:0]  f3;
        logic [31:0] addr, sdata, rdata;
        int          waits;
        logic        mis;
        logic [31:0] baddr;
        logic [3:0]  strb;
        logic [31:0] wdata, data;
    } vec_t;

    int n_vec = 0, n_bad = 0;
    logic [31:0] exp_q[$];
    vec_t tbl[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // waits == 255 means BUS_Ready is never given, so the access must time out
    task automatic run(input vec_t v);
        int n, vc, exp_n, exp_vc;
        logic act;
        act = (v.ren | v.wen) & ~v.mis;
        exp_vc = !act ? 0 : (v.waits == 255) ? T : v.waits + 1;
        exp_n  = !act ? 0 : exp_vc + 1;
        Mem_R_En_M = v.ren; Mem_W_En_M = v.wen; Funct3_M = v.f3;
        ALU_Out_M = v.addr; Store_Data_M = v.sdata; BUS_Rdata = v.rdata; BUS_Ready = 1'b0;
        #1;
        check("idle_valid", BUS_Valid, 0);
        if (exp_q.size() > 0) check("wb_data", Data_Out_Ext_M, exp_q.pop_front());
        exp_q.push_back(v.data);
        check("misalign", Misalign_M, v.mis);
        check("stall_first", Stall_M, act);
        n = 0; vc = 0;
        while (Stall_M && n < 300) begin
            if (BUS_Valid) begin
                check("bus_addr", BUS_Addr, v.baddr);
                check("bus_we", BUS_We, v.wen & ~v.ren);
                check("bus_strb", BUS_Strb, v.strb);
                if (v.wen & ~v.ren) check("bus_wdata", BUS_Wdata, v.wdata);
                BUS_Ready = (vc == v.waits);
                vc++;
            end
            n++;
            @(negedge CLK);
            BUS_Ready = 1'b0;
        end
        check("stall_cycles", n, exp_n);
        check("valid_cycles", vc, exp_vc);
        check("bus_err", Bus_Err_M, act && v.waits == 255);
        check("done_valid", BUS_Valid, 0);
        @(negedge CLK);
    endtask

    initial begin
        //        ren   wen   f3      addr           sdata          rdata     waits mis  baddr          strb     wdata          data
        tbl[0]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,         32'h80FF_1234, 1, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,         32'hFFFF_FF80};
        tbl[1]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_BEEF, 32'h0,         0, 1'b0, 32'h0000_0200, 4'b1100, 32'hBEEF_BEEF, 32'hFFFF_FF80};
        tbl[2]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0001, 32'h0,         32'h0,         0, 1'b1, 32'h0,         4'b0000, 32'h0,         32'hFFFF_FF80};
        tbl[3]  = '{1'b1, 1'b0, 3'b101, 32'h0000_0010, 32'h0,         32'h0000_F00D, 0, 1'b0, 32'h0000_0010, 4'b0000, 32'h0,         32'h0000_F00D};
        tbl[4]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0014, 32'h0,         32'h1234_5678, 0, 1'b0, 32'h0000_0014, 4'b0000, 32'h0,         32'h1234_5678};
        tbl[5]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0012, 32'h0,         32'h8001_0000, 0, 1'b0, 32'h0000_0010, 4'b0000, 32'h0,         32'hFFFF_8001};
        tbl[6]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0021, 32'h0,         32'h0000_AB00, 3, 1'b0, 32'h0000_0020, 4'b0000, 32'h0,         32'h0000_00AB};
        tbl[7]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0033, 32'h1234_5678, 32'h0,         0, 1'b0, 32'h0000_0030, 4'b1000, 32'h7878_7878, 32'h0000_00AB};
        tbl[8]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0,         1, 1'b0, 32'h0000_0040, 4'b1111, 32'hDEAD_BEEF, 32'h0000_00AB};
        tbl[9]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0042, 32'hDEAD_BEEF, 32'h0,         0, 1'b1, 32'h0,         4'b0000, 32'h0,         32'h0000_00AB};
        tbl[10] = '{1'b1, 1'b0, 3'b010, 32'h0000_0050, 32'h0,         32'h5555_5555, 255, 1'b0, 32'h0000_0050, 4'b0000, 32'h0,       32'h0000_0000};
        tbl[11] = '{1'b1, 1'b0, 3'b010, 32'h0000_0054, 32'h0,         32'hCAFE_F00D, 2, 1'b0, 32'h0000_0054, 4'b0000, 32'h0,         32'hCAFE_F00D};
        tbl[12] = '{1'b1, 1'b0, 3'b011, 32'h0000_0060, 32'h0,         32'h1122_3344, 0, 1'b0, 32'h0000_0060, 4'b0000, 32'h0,         32'h1122_3344};
        tbl[13] = '{1'b1, 1'b1, 3'b000, 32'h0000_0071, 32'hFFFF_FFFF, 32'h0000_5500, 0, 1'b0, 32'h0000_0070, 4'b0000, 32'h0,         32'h0000_0055};
        tbl[14] = '{1'b1, 1'b0, 3'b001, 32'h0000_0013, 32'h0,         32'h0,         0, 1'b1, 32'h0,         4'b0000, 32'h0,         32'h0000_0055};
        tbl[15] = '{1'b0, 1'b0, 3'b000, 32'h0,         32'h0,         32'h0,         0, 1'b0, 32'h0,         4'b0000, 32'h0,         32'h0000_0055};
        tbl[16] = '{1'b1, 1'b0, 3'b010, 32'h0000_0084, 32'h0,         32'h0BAD_F00D, 0, 1'b0, 32'h0000_0084, 4'b0000, 32'h0,         32'h0BAD_F00D};

        repeat (3) @(negedge CLK);
        check("rst_valid", BUS_Valid, 0);
        check("rst_we", BUS_We, 0);
        check("rst_addr", BUS_Addr, 0);
        check("rst_wdata", BUS_Wdata, 0);
        check("rst_strb", BUS_Strb, 0);
        check("rst_data", Data_Out_Ext_M, 0);
        check("rst_err", Bus_Err_M, 0);
        Mem_R_En_M = 1'b1; Funct3_M = 3'b010; ALU_Out_M = 32'h1;
        #1;
        check("rst_misalign", Misalign_M, 1);
        check("rst_stall_mis", Stall_M, 0);
        ALU_Out_M = 32'h4;
        #1;
        check("rst_stall", Stall_M, 1);
        Mem_R_En_M = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);

        for (int i = 0; i < 16; i++) run(tbl[i]);

        // reset asserted in the middle of a REQ cycle
        Mem_R_En_M = 1'b1; Mem_W_En_M = 1'b0; Funct3_M = 3'b010; ALU_Out_M = 32'h80; BUS_Ready = 1'b0;
        @(negedge CLK);
        check("req_valid", BUS_Valid, 1);
        check("req_stall", Stall_M, 1);
        #2 RST_N = 1'b0;
        #1;
        check("arst_valid", BUS_Valid, 0);
        check("arst_addr", BUS_Addr, 0);
        check("arst_data", Data_Out_Ext_M, 0);
        check("arst_err", Bus_Err_M, 0);
        check("arst_stall", Stall_M, 1);
        Mem_R_En_M = 1'b0;
        exp_q.delete();
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        run(tbl[16]);
        run(tbl[15]);
        check("final_data", Data_Out_Ext_M, 32'h0BAD_F00D);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/dmem_access_unit.md
# dmem_access_unit

Memory-stage data-memory initiator. It turns a load or store from the EX/MEM register into a transaction on the valid/ready data bus, and stalls the pipeline until the transaction completes. It supplies the registered, sign- or zero-extended load result `Data_Out_Ext_M`. Because the MEM/WB register passes `Data_Out_Ext` straight through without re-registering it, this block owns the synchronous timing of load data: the value must be stable for the whole writeback cycle.

## Interface
- `TIMEOUT_CYCLES`, 16: maximum cycles `BUS_Valid` may wait for `BUS_Ready` before the access aborts (range 2..255).
- `CLK` in 1: single clock; all state updates on the rising edge.
- `RST_N` in 1: reset, asynchronous and active-low.
- `Mem_R_En_M` in 1: load in the memory stage.
- `Mem_W_En_M` in 1: store in the memory stage. If both enables are high, the access is treated as a load.
- `Funct3_M` in 3: access size. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- `ALU_Out_M` in 32: byte address.
- `Store_Data_M` in 32: store source register value, unaligned.
- `Stall_M` out 1: freezes IF through MEM; combinational.
- `Misalign_M` out 1: misaligned access detected; combinational, no bus access made.
- `Bus_Err_M` out 1: one-cycle pulse when an access times out.
- `Data_Out_Ext_M` out 32: extended load result; registered.
- `BUS_Valid` out 1: request valid.
- `BUS_We` out 1: 1 = write.
- `BUS_Addr` out 32: word address, with `[1:0]` forced to 00.
- `BUS_Wdata` out 32: store data shifted into its byte lanes.
- `BUS_Strb` out 4: byte write enables; 0000 for reads.
- `BUS_Ready` in 1: responder accepts the request; on a read, `BUS_Rdata` is valid in the same cycle.
- `BUS_Rdata` in 32: read word.

## Operation
- **States:**
  - IDLE: no transaction.
  - REQ: `BUS_Valid` = 1, waiting for `BUS_Ready`.
  - DONE: one cycle that releases the stall.
- **Misalignment:**
  - `Misalign_M` = access enabled AND ((halfword AND `addr[0]`) OR (word AND `addr[1:0]` ≠ 0)).
  - A misaligned access never leaves IDLE, never stalls, and leaves `Data_Out_Ext_M` unchanged.
- **IDLE:** when an access is enabled and aligned:
  - `Stall_M` = 1.
  - At the next edge: register the bus fields, load the timeout counter with `TIMEOUT_CYCLES`-1, go to REQ.
- **REQ:** `Stall_M` = 1. At the edge:
  - If `BUS_Ready` = 1 on a load: capture the extracted byte/halfword/word into `Data_Out_Ext_M`, go to DONE.
  - If `BUS_Ready` = 1 on a store: go to DONE; `Data_Out_Ext_M` is unchanged.
  - Else if the counter = 0: set `Data_Out_Ext_M` = 0, pulse `Bus_Err_M` in the next cycle, go to DONE.
  - Else: decrement the counter.
- **DONE:** `Stall_M` = 0, so the instruction advances to WB at the next edge. Always return to IDLE, even if another access is already present. A new request starts from IDLE in the following cycle.
- **Bus rule:** while `BUS_Valid` = 1, `BUS_We`, `BUS_Addr`, `BUS_Wdata` and `BUS_Strb` are held constant. `BUS_Valid` drops in the cycle after the handshake or timeout.
- **Store lanes:**
  - SB: strobe = 0001 << `addr[1:0]`, with the byte replicated on all lanes.
  - SH: strobe = 0011 << `addr[1:0]`, with the halfword replicated.
  - SW: strobe = 1111.
- **Load extract:**
  - Byte lane = `BUS_Rdata` >> (8·`addr[1:0]`).
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
  - Undefined funct3 values behave as LW / SW.
- **Holding the result:** `Data_Out_Ext_M` changes only on a load capture, a timeout, or reset. It therefore holds through the writeback cycle regardless of later stalls or a store in MEM.

## Timing
- **Reset** (async assert, sync release), `RST_N` = 0:
  - State = IDLE, counter = 0.
  - `BUS_Valid`, `BUS_We` = 0; `BUS_Addr`, `BUS_Wdata`, `Data_Out_Ext_M` = 0; `BUS_Strb` = 0000.
  - `Bus_Err_M` = 0.
  - `Stall_M` and `Misalign_M` follow their inputs combinationally.
- **Reset mid-REQ:** `BUS_Valid` falls immediately without waiting for a clock edge. The responder must discard the request.
- **Zero-wait load:**
  - Cycle 0: IDLE, stall.
  - Cycle 1: REQ with `Ready` = 1, capture.
  - Cycle 2: DONE, no stall.
  - Cycle 3: WB, where `Data_Out_Ext_M` is valid.
  - Minimum penalty: 2 stall cycles; each wait state adds 1.
- **Timeout:** `BUS_Valid` is high for exactly `TIMEOUT_CYCLES` cycles. `Bus_Err_M` is high in the DONE cycle.
- **Combinational paths:** `Stall_M` and `Misalign_M` depend on inputs and state only; there is no combinational path from `BUS_Ready` to `BUS_*` outputs.

## Test plan
- **LB with sign extension:** `addr` = 0x103, `Rdata` = 0x80FF_1234 with 1 wait state → `BUS_Addr` = 0x100, `Strb` = 0000, `Stall_M` high for 3 cycles, `Data_Out_Ext_M` = 0xFFFF_FF80, held through WB.
- **SH at addr 0x202:** `Store_Data_M` = 0x0000_BEEF, `Ready` = 1 immediately → `Strb` = 1100, `Wdata` = 0xBEEF_BEEF, `We` = 1, `Data_Out_Ext_M` unchanged.
- **LW at 0x001** → `Misalign_M` = 1, `Stall_M` = 0, `BUS_Valid` never asserted.
- **Timeout:** `Ready` held low with `TIMEOUT_CYCLES` = 4 → `Valid` high for exactly 4 cycles, then `Bus_Err_M` pulses, `Data_Out_Ext_M` = 0, and the pipeline resumes.
- **Back-to-back:** LHU from 0x10 (`Rdata` = 0x0000_F00D) followed by LW from 0x14 (`Rdata` = 0x1234_5678) → `Data_Out_Ext_M` = 0x0000_F00D, then 0x1234_5678, with one IDLE cycle between.
- **Reset mid-REQ:** `RST_N` low in a REQ cycle → `BUS_Valid` = 0 immediately and all outputs take their reset values. After release, the next load completes normally.
